frame_pusher: RTL and testbench
===============================

# frame_pusher

Multi-cycle stack-frame writer for CALL and INT in the pipelined processor's memory stage. It captures a 32-bit return PC and, for INT, the 3-bit flags. It serialises them into 16-bit downward-growing stack writes: low PC half, high PC half, then flags. The pop-side accumulator therefore receives them in the order flags, high, low. It stalls the pipeline while the frame is being written and drives the shared stack-pointer register's update port.

## Interface
- ADDR_W, 32, address and stack-pointer width
- DATA_W, 16, memory word width
- FLAG_W, 3, flag field width (zero-extended to DATA_W when written)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a frame push, sampled in IDLE
- kind  in  1  0 = CALL (PC only, 2 words), 1 = INT (PC + flags, 3 words)
- ret_pc  in  ADDR_W  return PC, captured at start
- flags  in  FLAG_W  flags, captured at start
- hold  in  1  external memory-port stall; freezes write states
- sp_in  in  ADDR_W  current stack pointer, captured at start
- stall  out  1  pipeline freeze request
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- sp_we  out  1  stack-pointer register load enable
- sp_next  out  ADDR_W  new stack-pointer value
- done  out  1  one-cycle pulse after the final write

## Operation
- States:
  - IDLE
  - PUSH_LO
  - PUSH_HI
  - PUSH_FL
- IDLE with start=1: capture ret_pc, flags, kind, and sp_in into ptr, then go to PUSH_LO. start is ignored in all other states.
- Each write state with hold=0 performs these actions in the same cycle:
  - mem_we=1, mem_addr=ptr
  - sp_we=1, sp_next=ptr-1
- On the clock edge after such a write, ptr is decremented (post-decrement push).
- Data per write state:
  - PUSH_LO writes ret_pc[15:0].
  - PUSH_HI writes ret_pc[31:16].
  - PUSH_FL writes {13'b0, flags}.
- Transitions:
  - PUSH_LO → PUSH_HI.
  - PUSH_HI → PUSH_FL if kind=1, else IDLE.
  - PUSH_FL → IDLE.
- hold=1 in a write state forces mem_we=0 and sp_we=0. State and ptr are unchanged.
- hold has no effect in IDLE; start is still accepted there.
- stall = start&&IDLE || state!=IDLE. It is combinational, so the pipeline freezes in the accepting cycle.
- mem_addr and mem_wdata are don't-care when mem_we=0; drive them to 0.
- Arithmetic: ptr-1 is modulo 2^ADDR_W, so 0 wraps to all-ones (see Configuration).
- Reset mid-frame returns to IDLE immediately. Words already written stay in memory; no further writes occur.

## Timing
- Reset values:
  - state=IDLE, ptr=0
  - stall=0, mem_we=0, mem_addr=0, mem_wdata=0
  - sp_we=0, sp_next=0
  - done=0
- Write latency with no hold: first write in cycle N+1 after start is accepted in cycle N.
- CALL writes in N+1..N+2, with done registered in N+3.
- INT writes in N+1..N+3, with done in N+4.
- Each hold cycle adds one cycle.
- stall is high in cycles N..N+2 (CALL) or N..N+3 (INT). It falls in the cycle done rises.
- A new start is legal in the done cycle.
- Write timing: memory writes on the edge ending the strobe cycle, and the sp register loads on the same edge.

## Configuration
- Macro FRAME_PUSHER_STACK_GUARD_EN.
- Defined: adds parameter STACK_LIMIT (default 0) and output stack_ovf (1 bit, reset 0).
  - At start, if sp_in − (words−1) < STACK_LIMIT or the subtraction wraps, the frame is rejected.
  - On rejection there are no writes and no sp_we, and the block stays in IDLE.
  - stack_ovf pulses for one cycle after the start cycle, and done is not pulsed.
  - stall is high only in the start cycle.
- Undefined: no check is made, the stack pointer wraps silently, and the port and parameter are absent.

## Structure
- Shared package frame_pkg holds:
  - the state enum (IDLE, PUSH_LO, PUSH_HI, PUSH_FL)
  - KIND_CALL=0, KIND_INT=1
  - CALL_WORDS=2, INT_WORDS=3
  - width constants, shared with the pop-side accumulator so the word order is defined once
- Flat module. No sub-module is warranted; the word-select mux is inline.

## Test plan
- CALL, ret_pc=32'h1234_5678, sp_in=32'h0000_0FFF → writes:
  - 5678@0FFF
  - 1234@0FFE
  - sp_next 0FFE then 0FFD, done in N+3.
- INT, ret_pc=32'hDEAD_BEEF, flags=3'b101, sp_in=32'h0100 → writes:
  - BEEF@0100
  - DEAD@00FF
  - 0005@00FE
  - final sp_next=00FD, stall high 4 cycles.
- INT with hold=1 for 2 cycles during PUSH_HI → no mem_we in those cycles. DEAD then written at 00FF and done is delayed to N+6.
- rst_n low during PUSH_HI → all outputs 0 immediately, only the PUSH_LO word is written, and start is accepted normally after release.
- start pulses while busy, plus back-to-back start in the done cycle → the busy pulses are ignored and the second frame starts cleanly.
- Wrap or guard case: CALL with sp_in=0.
  - Without guard: writes at 0 and FFFF_FFFF.
  - With guard and STACK_LIMIT=0: stack_ovf=1, no writes.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared stack-frame definitions for the push-side writer and pop-side accumulator.
// Word order on the stack: low PC half, high PC half, then flags for INT frames.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    PUSH_FL = 2'd3
  } frame_state_t;

  localparam int FRAME_ADDR_W = 32;
  localparam int FRAME_DATA_W = 16;
  localparam int FRAME_FLAG_W = 3;

  localparam logic KIND_CALL = 1'b0;
  localparam logic KIND_INT  = 1'b1;

  localparam int CALL_WORDS = 2;
  localparam int INT_WORDS  = 3;

  function automatic int frame_words(input logic kind);
    return (kind == KIND_INT) ? INT_WORDS : CALL_WORDS;
  endfunction

endpackage

// File: rtl/frame_pusher.sv
// Serialises a CALL/INT return frame into 16-bit downward-growing stack writes.
// Optional stack guard: define FRAME_PUSHER_STACK_GUARD_EN to add STACK_LIMIT and stack_ovf.
//
// state   | meaning
// IDLE    | waiting for start; capture frame and stack pointer on accept
// PUSH_LO | write ret_pc low half at ptr
// PUSH_HI | write ret_pc high half at ptr; CALL frames finish here
// PUSH_FL | write zero-extended flags at ptr (INT only)
module frame_pusher
  import frame_pkg::*;
#(
  parameter int ADDR_W = FRAME_ADDR_W,
  parameter int DATA_W = FRAME_DATA_W,
  parameter int FLAG_W = FRAME_FLAG_W
`ifdef FRAME_PUSHER_STACK_GUARD_EN
  ,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = '0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              kind,
  input  logic [ADDR_W-1:0] ret_pc,
  input  logic [FLAG_W-1:0] flags,
  input  logic              hold,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_next,
  output logic              done
`ifdef FRAME_PUSHER_STACK_GUARD_EN
  ,
  output logic              stack_ovf
`endif
);

  frame_state_t      state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_dec;
  logic [ADDR_W-1:0] pc_q;
  logic [FLAG_W-1:0] flags_q;
  logic              kind_q;
  logic              idle_start;
  logic              reject;
  logic              accept;
  logic              write;
  logic              last_write;
  logic [DATA_W-1:0] word;

  assign idle_start = start && (state == IDLE);
  assign accept     = idle_start && !reject;
  assign ptr_dec    = ptr - {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef FRAME_PUSHER_STACK_GUARD_EN
  // Lowest address the frame would touch, with a borrow bit to catch wrap below zero.
  logic [ADDR_W:0]   sp_floor;
  logic [ADDR_W-1:0] span;
  logic              ovf_q;

  assign span     = ADDR_W'(frame_words(kind) - 1);
  assign sp_floor = {1'b0, sp_in} - {1'b0, span};
  assign reject   = sp_floor[ADDR_W] || (sp_floor[ADDR_W-1:0] < STACK_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= idle_start && reject;
    end
  end

  assign stack_ovf = ovf_q;
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      kind_q  <= KIND_CALL;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last_write;
      if (accept) begin
        ptr     <= sp_in;
        pc_q    <= ret_pc;
        flags_q <= flags;
        kind_q  <= kind;
      end else if (write) begin
        ptr <= ptr_dec;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    write      = 1'b0;
    last_write = 1'b0;
    word       = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = PUSH_LO;
      end
      PUSH_LO: begin
        word = pc_q[DATA_W-1:0];
        if (!hold) begin
          write     = 1'b1;
          state_nxt = PUSH_HI;
        end
      end
      PUSH_HI: begin
        word = pc_q[2*DATA_W-1:DATA_W];
        if (!hold) begin
          write = 1'b1;
          if (kind_q == KIND_INT) begin
            state_nxt = PUSH_FL;
          end else begin
            state_nxt  = IDLE;
            last_write = 1'b1;
          end
        end
      end
      PUSH_FL: begin
        word = {{(DATA_W-FLAG_W){1'b0}}, flags_q};
        if (!hold) begin
          write      = 1'b1;
          last_write = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the accepting cycle itself.
  assign stall     = idle_start || (state != IDLE);
  assign mem_we    = write;
  assign mem_addr  = write ? ptr : '0;
  assign mem_wdata = write ? word : '0;
  assign sp_we     = write;
  assign sp_next   = write ? ptr_dec : '0;

endmodule

// File: tb/tb_frame_pusher.sv
// Self-checking bench for frame_pusher: frames are expanded into expected word lists
// (address sp-i, post-decremented sp) and compared cycle by cycle.
module tb_frame_pusher;
  import frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        kind = 1'b0;
  logic [31:0] ret_pc = '0;
  logic [2:0]  flags = '0;
  logic        hold = 1'b0;
  logic [31:0] sp_in = '0;
  logic        stall, mem_we, sp_we, done;
  logic [31:0] mem_addr, sp_next;
  logic [15:0] mem_wdata;
`ifdef FRAME_PUSHER_STACK_GUARD_EN
  logic        stack_ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit done_pending = 1'b0;

  wire [83:0] obs_v = {stall, mem_we, mem_addr, mem_wdata, sp_we, sp_next, done};

  always #5 clk = ~clk;

  frame_pusher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kind      (kind),
    .ret_pc    (ret_pc),
    .flags     (flags),
    .hold      (hold),
    .sp_in     (sp_in),
    .stall     (stall),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .sp_we     (sp_we),
    .sp_next   (sp_next),
    .done      (done)
`ifdef FRAME_PUSHER_STACK_GUARD_EN
    ,
    .stack_ovf (stack_ovf)
`endif
  );

  task automatic scramble_inputs();
    kind   = 1'($urandom_range(1));
    ret_pc = $urandom;
    flags  = 3'($urandom_range(7));
    sp_in  = $urandom;
  endtask

  task automatic test_reset();
    logic [83:0] exp_v;
    #1 rst_n = 1'b0;
    #1;
    exp_v = '0;
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs_v, exp_v);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs_v, exp_v);
    end
    done_pending = 1'b0;
  endtask

  // Full frame: start cycle, then every write, honouring forced and random hold cycles.
  task automatic frame(input logic k, input logic [31:0] pc, input logic [2:0] fl,
                       input logic [31:0] sp, input int hold_pct, input int hold_at,
                       input int hold_len, input bit busy_starts);
    logic [15:0] words[$];
    logic [83:0] exp_v;
    int idx = 0;
    int held = 0;
    int cyc = 0;
    bit forced;
    words.push_back(pc[15:0]);
    words.push_back(pc[31:16]);
    if (k == KIND_INT) words.push_back({13'b0, fl});

    @(posedge clk);
    #1;
    start = 1'b1; kind = k; ret_pc = pc; flags = fl; sp_in = sp;
    hold = 1'($urandom_range(1));
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, done_pending};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL frame_start: got %h expected %h", obs_v, exp_v);
    end
    done_pending = 1'b0;

    while (idx < words.size() && cyc < 64) begin
      cyc++;
      @(posedge clk);
      #1;
      start = busy_starts ? 1'($urandom_range(1)) : 1'b0;
      scramble_inputs();
      forced = (idx == hold_at) && (held < hold_len);
      if (forced) held++;
      hold = forced || (int'($urandom_range(99)) < hold_pct);
      @(negedge clk);
      if (hold)
        exp_v = {1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0};
      else
        exp_v = {1'b1, 1'b1, sp - 32'(idx), words[idx], 1'b1, sp - 32'(idx) - 32'd1, 1'b0};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL frame_word%0d hold=%0d: got %h expected %h", idx, hold, obs_v, exp_v);
      end
      if (!hold) idx++;
    end
    if (idx < words.size()) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d words expected %0d", idx, words.size());
    end
    done_pending = 1'b1;
  endtask

  task automatic idle_cycle();
    logic [83:0] exp_v;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    hold = 1'($urandom_range(1));
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, done_pending};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL idle_cycle: got %h expected %h", obs_v, exp_v);
    end
    done_pending = 1'b0;
  endtask

  task automatic test_call();
    frame(KIND_CALL, 32'h1234_5678, 3'b000, 32'h0000_0FFF, 0, -1, 0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_int();
    frame(KIND_INT, 32'hDEAD_BEEF, 3'b101, 32'h0000_0100, 0, -1, 0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_hold();
    frame(KIND_INT, 32'hDEAD_BEEF, 3'b101, 32'h0000_0100, 0, 1, 2, 1'b0);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    logic [83:0] exp_v;
    @(posedge clk);
    #1;
    start = 1'b1; kind = KIND_INT; ret_pc = 32'hCAFE_F00D; flags = 3'b011;
    sp_in = 32'h0000_2000; hold = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    exp_v = {1'b1, 1'b1, 32'h0000_2000, 16'hF00D, 1'b1, 32'h0000_1FFF, 1'b0};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_lo: got %h expected %h", obs_v, exp_v);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_v = '0;
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", obs_v, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_pending = 1'b0;
    #1;
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_release: got %h expected %h", obs_v, exp_v);
    end
    idle_cycle();
    frame(KIND_CALL, 32'h0BAD_F00D, 3'b000, 32'h0000_2000, 0, -1, 0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    frame(KIND_CALL, 32'hA5A5_0001, 3'b000, 32'h0000_8000, 0, -1, 0, 1'b1);
    frame(KIND_INT,  32'h5A5A_0002, 3'b110, 32'h0000_7FFE, 0, -1, 0, 1'b1);
    frame(KIND_CALL, 32'h1111_2222, 3'b000, 32'h0000_7FFB, 0, -1, 0, 1'b1);
    idle_cycle();
  endtask

  task automatic test_wrap();
`ifdef FRAME_PUSHER_STACK_GUARD_EN
    logic [83:0] exp_v;
    @(posedge clk);
    #1;
    start = 1'b1; kind = KIND_CALL; ret_pc = 32'h7777_8888; sp_in = 32'h0; hold = 1'b0;
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, done_pending};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL guard_start: got %h expected %h", obs_v, exp_v);
    end
    done_pending = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    exp_v = '0;
    checks++;
    if ({obs_v, stack_ovf} !== {exp_v, 1'b1}) begin
      errors++;
      $display("FAIL guard_ovf: got %h/%b expected %h/1", obs_v, stack_ovf, exp_v);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({obs_v, stack_ovf} !== {exp_v, 1'b0}) begin
      errors++;
      $display("FAIL guard_after: got %h/%b expected %h/0", obs_v, stack_ovf, exp_v);
    end
`else
    frame(KIND_CALL, 32'h7777_8888, 3'b000, 32'h0000_0000, 0, -1, 0, 1'b0);
    idle_cycle();
`endif
  endtask

  task automatic test_random();
    logic [31:0] sp;
    for (int i = 0; i < 40; i++) begin
      sp = $urandom;
      if (sp < 32'd2) sp = 32'd2;
      frame(1'($urandom_range(1)), $urandom, 3'($urandom_range(7)), sp, 25, -1, 0, 1'b1);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_call();
    test_int();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
